spi_main_param: RTL and testbench
=================================

# spi_main_param

Parametrised SPI master: successor to the fixed 258-bit, mode-0, single-slave SPI main that carries AES key/message frames to the AES encrypt/decrypt slaves. It supports:
- runtime frame length up to `MAX_BITS`;
- runtime SPI mode (CPOL/CPHA);
- programmable SCLK divider;
- `NUM_CS` slave selects, so encrypt and decrypt cores can share one bus.

It sits between the host/test logic and the AES SPI slaves.

## Interface
Parameters:
- `MAX_BITS`, 258: maximum frame length in bits (covers the 2-bit key-size prefix plus a 256-bit key).
- `NUM_CS`, 2: number of chip-select lines.
- `DIV_W`, 8: width of the divider input.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `len` in LEN_W: frame length in bits, with LEN_W = clog2(MAX_BITS+1).
- `tx` in [0:MAX_BITS-1]: transmit data; `tx[0]` is sent first.
- `cs_sel` in clog2(NUM_CS): index of the target slave.
- `cpol`, `cpha` in 1 each: SPI mode.
- `clk_div` in DIV_W: SCLK half-period minus one, in `clk` cycles.
- `rx` out [0:MAX_BITS-1]: received data; first received bit is at index 0.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `sclk`, `mosi` out 1 each: SPI clock and data out.
- `miso` in 1: SPI data in.
- `cs_n` out NUM_CS: active-low selects.

## Operation
- At `start` in IDLE, latch `len`, `tx`, `cs_sel`, `cpol`, `cpha`, `clk_div`. Later input changes have no effect until the next start.
- H = latched `clk_div` + 1.
- State machine: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
  - IDLE: `sclk` follows the `cpol` input, registered.
  - SETUP, H cycles: `cs_n[cs_sel]` low, `sclk` idle.
  - XFER: 2·len half-periods of H cycles each.
  - HOLD, H cycles: `sclk` idle, `cs_n` still low.
  - Return to IDLE: all `cs_n` high, `done` = 1 for one cycle.
- `cpha` = 0:
  - `mosi` = bit 0 from SETUP entry.
  - `miso` sampled on each leading edge; `mosi` advances on each trailing edge.
- `cpha` = 1:
  - `mosi` advances on each leading edge, starting with bit 0 on the first.
  - `miso` sampled on each trailing edge.
- Leading edge means idle level -> active level (cpol=0: rising).
- `rx` update:
  - Bit k lands in `rx[k]`.
  - `rx[len:MAX_BITS-1]` are forced to 0 at start.
  - `rx` is stable from `done` until the next accepted start.
- Boundary cases:
  - `len` = 0 at start: no CS/SCLK activity; `done` pulses on the next cycle; `rx` = 0.
  - `len` > MAX_BITS: clamp to MAX_BITS.
  - `cs_sel` >= NUM_CS: the frame runs with no `cs_n` asserted.
  - `start` while busy: ignored, no queuing.
  - `start` in the same cycle as `done`: ignored; `start` is accepted one cycle later.
  - `rst_n` low at any time: immediately IDLE, all outputs at reset values, frame lost.
- Reset values:
  - `sclk` = 0, `mosi` = 0.
  - `cs_n` = all 1.
  - `busy` = 0, `done` = 0.
  - `rx` = 0.

## Timing
- `start` sampled at edge E0: `busy` = 1 and `cs_n` low from E0.
- `done` asserts at E0 + H·(2·len + 2); at the same edge `busy` drops and `cs_n` rises.
- The first SCLK edge is at E0 + H; consecutive edges are H cycles apart.
- All SPI outputs are registered, with no combinational path from inputs to outputs.
- `miso` is sampled on the `clk` edge that generates the relevant SCLK edge. The slave's `sdo` must be stable one half-period before.

## Configuration
- `SPI_MAIN_PARAM_ABORT_EN` defined: adds input `abort` (1 bit).
  - Trigger: `abort` high while busy.
  - Next edge: IDLE, `cs_n` all high, `sclk` idle.
  - `busy` = 0, `done` not pulsed, `rx` cleared to 0.
  - Ignored in IDLE.
- Undefined: no `abort` port; frames always run to completion.

## Structure
- Package `spi_main_pkg`:
  - state enum (IDLE, SETUP, XFER, HOLD);
  - LEN_W/CS_W width functions;
  - mode constants MODE0..MODE3.
- Sub-module `spi_clk_gen`:
  - loads H at start;
  - emits a one-cycle half-period tick and a leading/trailing edge flag;
  - has its own `clk`/`rst_n`.
- The top level holds the FSM, bit counter (LEN_W+1 bits, counts half-periods), shift registers and CS decode.

## Test plan
- **Mode 0, no divide.** Settings: `clk_div` = 0, loopback `mosi`->`miso`, `len` = 130, `tx` = {2'b00, 128'h000102030405060708090a0b0c0d0e0f}. Required: `done` at E0+262, `rx[0:129]` equals `tx[0:129]`, `rx[130:257]` = 0.
- **Mode 3, divided.** Settings: `clk_div` = 3, `len` = 258, AES-256 frame with prefix 2'b10. Required: 129·2 SCLK periods of 8 `clk` cycles each; `sclk` idles high; `done` at E0+4·518; loopback `rx` = `tx`.
- **cpha = 1, second slave.** Settings: `cs_sel` = 1, `len` = 8, `tx[0:7]` = 8'hA5, miso slave model returns 8'h3C. Required: only `cs_n[1]` low; `rx[0:7]` = 8'h3C.
- **Start while busy and back-to-back.** Stimulus: `start` pulsed while busy, then `start` on the `done` cycle. Required: both ignored; the next `start` is accepted.
- **Edge cases.** Stimulus: `len` = 0, then `len` = 300. Required: `len` = 0 gives `done` at E0+1 with no `cs_n`/`sclk` toggles; `len` = 300 is clamped to 258.
- **Reset and abort.** Stimulus: `rst_n` low at mid-frame bit 40. Required: outputs return to reset values immediately. With `SPI_MAIN_PARAM_ABORT_EN`, `abort` at bit 40 gives `cs_n` high the next cycle, `rx` = 0, and no `done`.

Source files
------------

// File: rtl/spi_main_pkg.sv
// Shared state encoding, SPI mode constants and width helpers for the SPI master.
package spi_main_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } state_t;

   // Mode encoding is {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic int len_w(input int max_bits);
      return $clog2(max_bits + 1);
   endfunction

   function automatic int cs_w(input int num_cs);
      return (num_cs > 1) ? $clog2(num_cs) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one tick every H = div+1 cycles while enabled,
// plus a flag telling whether the next SCLK edge is the leading one.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   input  logic             i_en,
   input  logic             i_edge_en,
   output logic             o_tick,
   output logic             o_lead
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_lead;

   assign o_tick = i_en && (r_cnt == r_div);
   assign o_lead = r_lead;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_cnt  <= '0;
         r_lead <= 1'b1;
      end else if (i_load) begin
         r_div  <= i_div;
         r_cnt  <= '0;
         r_lead <= 1'b1;
      end else if (i_en) begin
         if (o_tick) begin
            r_cnt <= '0;
            if (i_edge_en) r_lead <= ~r_lead;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_main_param.sv
// Parametrised SPI master: runtime length, mode, divider and slave select.
// Optional abort input is built in with SPI_MAIN_PARAM_ABORT_EN.
module spi_main_param
   import spi_main_pkg::*;
#(
   parameter int MAX_BITS = 258,
   parameter int NUM_CS   = 2,
   parameter int DIV_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [len_w(MAX_BITS)-1:0]  len,
   input  logic [0:MAX_BITS-1]         tx,
   input  logic [cs_w(NUM_CS)-1:0]     cs_sel,
   input  logic                        cpol,
   input  logic                        cpha,
   input  logic [DIV_W-1:0]            clk_div,
   output logic [0:MAX_BITS-1]         rx,
   output logic                        busy,
   output logic                        done,
   output logic                        sclk,
   output logic                        mosi,
   input  logic                        miso,
`ifdef SPI_MAIN_PARAM_ABORT_EN
   input  logic                        abort,
`endif
   output logic [NUM_CS-1:0]           cs_n
);

   localparam int LEN_W = len_w(MAX_BITS);
   localparam int CS_W  = cs_w(NUM_CS);

   state_t              r_state;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W:0]      r_hcnt;
   logic [0:MAX_BITS-1] r_tx;
   logic [0:MAX_BITS-1] r_rx;
   logic                r_cpol;
   logic                r_cpha;
   logic                r_sclk;
   logic                r_mosi;
   logic [NUM_CS-1:0]   r_cs_n;
   logic                r_busy;
   logic                r_done;
   logic                r_zero;

   logic [LEN_W-1:0]    w_len;
   logic                w_zero;
   logic [NUM_CS-1:0]   w_cs_dec;
   logic                w_accept;
   logic                w_tick;
   logic                w_lead;
   logic                w_last;
   logic                w_edge_en;
   logic                w_edge;
   logic                w_sample;
   logic [LEN_W-1:0]    w_bit;
   logic                w_abort;

`ifdef SPI_MAIN_PARAM_ABORT_EN
   assign w_abort = abort && r_busy;
`else
   assign w_abort = 1'b0;
`endif

   assign w_len    = (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
   assign w_zero   = (w_len == '0);
   assign w_accept = (r_state == IDLE) && start && !r_done;
   assign w_last   = (r_hcnt == {r_len, 1'b0});

   // Edge k (1-based) is produced by tick k; the tick after the last edge ends XFER
   assign w_edge_en = (r_state == SETUP) ||
                      ((r_state == XFER) && !w_last);
   assign w_edge    = w_tick && w_edge_en;
   assign w_sample  = w_lead ^ r_cpha;
   assign w_bit     = r_hcnt[LEN_W:1];

   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) w_cs_dec[i] = 1'b0;
      end
   end

   spi_clk_gen #(
      .DIV_W (DIV_W)
   ) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_accept),
      .i_div     (clk_div),
      .i_en      (r_state != IDLE),
      .i_edge_en (w_edge_en),
      .o_tick    (w_tick),
      .o_lead    (w_lead)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_hcnt  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= '1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_sclk <= cpol;
               if (w_accept) begin
                  r_len  <= w_len;
                  r_tx   <= tx;
                  r_cpol <= cpol;
                  r_cpha <= cpha;
                  r_rx   <= '0;
                  r_hcnt <= '0;
                  r_busy <= 1'b1;
                  r_zero <= w_zero;
                  if (w_zero) begin
                     r_state <= HOLD;
                  end else begin
                     r_state <= SETUP;
                     r_cs_n  <= w_cs_dec;
                     r_mosi  <= cpha ? 1'b0 : tx[0];
                  end
               end
            end
            SETUP: begin
               if (w_tick) r_state <= XFER;
            end
            XFER: begin
               if (w_tick && w_last) r_state <= HOLD;
            end
            HOLD: begin
               if (w_tick || r_zero) begin
                  r_state <= IDLE;
                  r_cs_n  <= '1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_zero  <= 1'b0;
                  r_sclk  <= r_cpol;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_edge) begin
            r_sclk <= ~r_sclk;
            r_hcnt <= r_hcnt + (LEN_W+1)'(1);
            if (w_sample) begin
               r_rx[w_bit] <= miso;
            end else begin
               r_mosi <= r_cpha ? r_tx[0] : r_tx[1];
               r_tx   <= r_tx << 1;
            end
         end

         if (w_abort) begin
            r_state <= IDLE;
            r_cs_n  <= '1;
            r_sclk  <= r_cpol;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rx    <= '0;
            r_zero  <= 1'b0;
         end
      end
   end

   assign rx   = r_rx;
   assign busy = r_busy;
   assign done = r_done;
   assign sclk = r_sclk;
   assign mosi = r_mosi;
   assign cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_main_param.sv
// Scoreboard bench for spi_main_param; abort checks are built when
// SPI_MAIN_PARAM_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_spi_main_param;

   localparam int MB = 258;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [8:0]    len = '0;
   logic [0:MB-1] tx = '0;
   logic [0:0]    cs_sel = '0;
   logic          cpol = 1'b0;
   logic          cpha = 1'b0;
   logic [7:0]    clk_div = '0;
   logic [0:MB-1] rx;
   logic          busy;
   logic          done;
   logic          sclk;
   logic          mosi;
   logic          miso;
   logic [1:0]    cs_n;
`ifdef SPI_MAIN_PARAM_ABORT_EN
   logic          abort = 1'b0;
`endif

   bit         use_slv = 0;
   logic [0:7] slv_pat = 8'h3C;
   logic [0:7] slv_rx = '0;
   logic       slv_sdo = 1'b0;
   int         slv_idx = 0;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [0:MB-1] rx;
      int            lat;
      logic [1:0]    csn;
      int            tog;
      int            h;
      logic          pol;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign miso = use_slv ? slv_sdo : mosi;

   // Slave model for cpol=0/cpha=1 on select 1
   always @(posedge sclk) begin
      if (use_slv && !cs_n[1] && slv_idx < 8) begin
         slv_sdo = slv_pat[slv_idx];
         slv_idx = slv_idx + 1;
      end
   end

   always @(negedge sclk) begin
      if (use_slv && !cs_n[1]) slv_rx = {slv_rx[1:7], mosi};
   end

   spi_main_param #(
      .MAX_BITS (MB),
      .NUM_CS   (2),
      .DIV_W    (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .len     (len),
      .tx      (tx),
      .cs_sel  (cs_sel),
      .cpol    (cpol),
      .cpha    (cpha),
      .clk_div (clk_div),
      .rx      (rx),
      .busy    (busy),
      .done    (done),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
`ifdef SPI_MAIN_PARAM_ABORT_EN
      .abort   (abort),
`endif
      .cs_n    (cs_n)
   );

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [0:MB-1] mask_rx(input logic [0:MB-1] v,
                                             input int l);
      logic [0:MB-1] r;
      r = '0;
      for (int i = 0; i < MB; i++) begin
         if (i < l) r[i] = v[i];
      end
      return r;
   endfunction

   task automatic run_frame(input string tag, input int l,
                            input logic [0:MB-1] t, input int csel,
                            input logic pol, input logic pha,
                            input int div, input bit slv,
                            input logic [0:MB-1] exp_rx,
                            input bit poke_busy, input bit poke_done);
      exp_t       e;
      exp_t       g;
      int         lc;
      int         e0;
      int         tog;
      int         first;
      int         last;
      int         budget;
      logic       prev;
      logic [1:0] csn_and;
      bit         got;

      lc    = (l > MB) ? MB : l;
      e.rx  = exp_rx;
      e.h   = div + 1;
      e.lat = (lc == 0) ? 1 : e.h * (2 * lc + 2);
      e.csn = 2'b11;
      if (lc != 0 && csel < 2) e.csn[csel] = 1'b0;
      e.tog = 2 * lc;
      e.pol = pol;

      @(negedge clk);
      len     = 9'(l);
      tx      = t;
      cs_sel  = 1'(csel);
      cpol    = pol;
      cpha    = pha;
      clk_div = 8'(div);
      use_slv = slv;
      slv_idx = 0;
      slv_rx  = '0;

      @(negedge clk);
      chk({tag, "_pre_idle"}, 512'(sclk), 512'(pol));
      start   = 1'b1;
      e0      = cyc + 1;
      prev    = sclk;
      csn_and = 2'b11;
      tog     = 0;
      first   = -1;
      last    = -1;
      got     = 0;
      sbq.push_back(e);
      budget  = e.lat + 20;

      for (int c = 0; c < budget && !got; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         if (poke_busy && c == 2) begin
            start = 1'b1;
            len   = 9'd1;
            tx    = ~t;
         end
         if (poke_busy && c == 3) start = 1'b0;
         if (sclk !== prev) begin
            tog++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         prev    = sclk;
         csn_and = csn_and & cs_n;
         if (done === 1'b1) got = 1;
      end

      g = sbq.pop_front();
      chk({tag, "_done"}, 512'(got), 512'(1));
      if (got) begin
         chk({tag, "_lat"}, 512'(cyc - e0), 512'(g.lat));
         chk({tag, "_rx"}, 512'(rx), 512'(g.rx));
         chk({tag, "_csn"}, 512'(csn_and), 512'(g.csn));
         chk({tag, "_tog"}, 512'(tog), 512'(g.tog));
         chk({tag, "_busy"}, 512'(busy), 512'(0));
         chk({tag, "_idle"}, 512'(sclk), 512'(g.pol));
         if (g.tog > 0) begin
            chk({tag, "_first"}, 512'(first - e0), 512'(g.h));
            chk({tag, "_span"}, 512'(last - first),
                512'((g.tog - 1) * g.h));
         end
         if (poke_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_ign_done"}, 512'(busy), 512'(0));
         end
      end
      use_slv = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [0:MB-1] t;
      logic [0:MB-1] ex;
      int            nd;

      repeat (3) @(negedge clk);
      chk("rst_sclk", 512'(sclk), 512'(0));
      chk("rst_mosi", 512'(mosi), 512'(0));
      chk("rst_csn", 512'(cs_n), 512'(2'b11));
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_done", 512'(done), 512'(0));
      chk("rst_rx", 512'(rx), 512'(0));
      rst_n = 1'b1;
      @(negedge clk);

      t = '1;
      t[0:129] = {2'b00, 128'h000102030405060708090a0b0c0d0e0f};
      run_frame("m0", 130, t, 0, 1'b0, 1'b0, 0, 0, mask_rx(t, 130), 0, 0);

      t = {2'b10,
           256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4};
      run_frame("m3", 258, t, 0, 1'b1, 1'b1, 3, 0, t, 0, 0);

      t = '0;
      t[0:7] = 8'hA5;
      ex = '0;
      ex[0:7] = 8'h3C;
      run_frame("c1", 8, t, 1, 1'b0, 1'b1, 1, 1, ex, 0, 0);
      chk("c1_mosi", 512'(slv_rx), 512'(8'hA5));

      for (int i = 0; i < MB; i++) t[i] = 1'($urandom);
      run_frame("bb", 4, t, 0, 1'b0, 1'b0, 0, 0, mask_rx(t, 4), 1, 1);
      run_frame("nxt", 6, t, 0, 1'b0, 1'b1, 0, 0, mask_rx(t, 6), 0, 0);

      run_frame("z", 0, t, 0, 1'b0, 1'b0, 2, 0, '0, 0, 0);

      for (int i = 0; i < MB; i++) t[i] = 1'($urandom);
      run_frame("cl", 300, t, 1, 1'b0, 1'b0, 0, 0, mask_rx(t, MB), 0, 0);

      // Reset in the middle of a frame, around bit 40
      t = '1;
      @(negedge clk);
      len = 9'd100;
      tx = t;
      cs_sel = 1'b0;
      cpol = 1'b1;
      cpha = 1'b0;
      clk_div = 8'd0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (80) @(negedge clk);
      chk("mid_busy", 512'(busy), 512'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_sclk", 512'(sclk), 512'(0));
      chk("mid_rst_mosi", 512'(mosi), 512'(0));
      chk("mid_rst_csn", 512'(cs_n), 512'(2'b11));
      chk("mid_rst_busy", 512'(busy), 512'(0));
      chk("mid_rst_done", 512'(done), 512'(0));
      chk("mid_rst_rx", 512'(rx), 512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef SPI_MAIN_PARAM_ABORT_EN
      cpol = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (80) @(negedge clk);
      chk("ab_busy_pre", 512'(busy), 512'(1));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_csn", 512'(cs_n), 512'(2'b11));
      chk("ab_busy", 512'(busy), 512'(0));
      chk("ab_rx", 512'(rx), 512'(0));
      chk("ab_sclk", 512'(sclk), 512'(0));
      nd = (done === 1'b1) ? 1 : 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("ab_nodone", 512'(nd), 512'(0));
`else
      nd = 0;
`endif

      chk("sb_empty", 512'(sbq.size()), 512'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
